// File: rtl/rggen_register_bus_initiator.sv
// rggen_register_bus_initiator: initiator end of the register-level bus.
// It takes one host request at a time and broadcasts it to every register
// instance in the block. It then merges their responses into one registered
// response.
// Optional feature: define RGGEN_REGISTER_BUS_TIMEOUT_EN to add a BUSY
// watchdog. The watchdog answers SLVERR after TIMEOUT_CYCLES cycles without
// ready.
module rggen_register_bus_initiator #(
  parameter int unsigned              ADDRESS_WIDTH       = 8,
  parameter int unsigned              LOCAL_ADDRESS_WIDTH = 8,
  parameter int unsigned              BUS_WIDTH           = 32,
  parameter int unsigned              REGISTERS           = 1,
  parameter bit                       PRE_DECODE          = 1'b0,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDRESS        = '0,
  parameter int unsigned              BYTE_SIZE           = 256,
  parameter bit                       ERROR_STATUS        = 1'b0,
  parameter logic [BUS_WIDTH-1:0]     DEFAULT_READ_DATA   = '0,
  parameter int unsigned              TIMEOUT_CYCLES      = 255
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_bus_valid,
  input  logic [1:0]                     i_bus_access,
  input  logic [ADDRESS_WIDTH-1:0]       i_bus_address,
  input  logic [BUS_WIDTH-1:0]           i_bus_write_data,
  input  logic [BUS_WIDTH-1:0]           i_bus_strobe,
  output logic                           o_bus_ready,
  output logic [1:0]                     o_bus_status,
  output logic [BUS_WIDTH-1:0]           o_bus_read_data,
  output logic                           o_register_valid,
  output logic [1:0]                     o_register_access,
  output logic [LOCAL_ADDRESS_WIDTH-1:0] o_register_address,
  output logic [BUS_WIDTH-1:0]           o_register_write_data,
  output logic [BUS_WIDTH-1:0]           o_register_strobe,
  input  logic [REGISTERS-1:0]           i_register_active,
  input  logic [REGISTERS-1:0]           i_register_ready,
  input  logic [2*REGISTERS-1:0]         i_register_status,
  input  logic [BUS_WIDTH*REGISTERS-1:0] i_register_read_data
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY     = 2'd1,
    RESPONSE = 2'd2
  } state_e;

  localparam int unsigned ADDR_LSB = $clog2(BUS_WIDTH / 8);
  localparam logic [LOCAL_ADDRESS_WIDTH-1:0] LOCAL_MASK =
    {LOCAL_ADDRESS_WIDTH{1'b1}} << ADDR_LSB;
  localparam logic [1:0] STATUS_OKAY   = 2'b00;
  localparam logic [1:0] STATUS_SLVERR = 2'b10;
  localparam logic [1:0] STATUS_DECERR = 2'b11;
  localparam logic [1:0] NO_HIT_STATUS = ERROR_STATUS ? STATUS_DECERR : STATUS_OKAY;

  state_e                         state_q;
  logic                           bus_ready_q;
  logic [1:0]                     status_q;
  logic [BUS_WIDTH-1:0]           read_data_q;
  logic                           register_valid_q;
  logic [1:0]                     access_q;
  logic [LOCAL_ADDRESS_WIDTH-1:0] address_q;
  logic [BUS_WIDTH-1:0]           write_data_q;
  logic [BUS_WIDTH-1:0]           strobe_q;

  logic [63:0]                    address_ext;
  logic [63:0]                    offset_ext;
  logic                           in_range;
  logic                           reject;
  logic [LOCAL_ADDRESS_WIDTH-1:0] local_address;

  logic [REGISTERS-1:0]           hit;
  logic                           any_active;
  logic                           any_hit;
  logic [1:0]                     hit_status;
  logic [BUS_WIDTH-1:0]           hit_data;
  logic                           timeout_expired;

  // Writes never return data, whatever the registers drive.
  function automatic logic [BUS_WIDTH-1:0] response_data(
    input logic                 is_write,
    input logic [BUS_WIDTH-1:0] data
  );
    return is_write ? '0 : data;
  endfunction

  // Block-relative offset, range check and word-aligned local address.
  assign address_ext   = 64'(i_bus_address);
  assign offset_ext    = address_ext - 64'(BASE_ADDRESS);
  assign in_range      = (address_ext >= 64'(BASE_ADDRESS)) && (offset_ext < 64'(BYTE_SIZE));
  assign reject        = PRE_DECODE && !in_range;
  assign local_address = LOCAL_ADDRESS_WIDTH'(offset_ext) & LOCAL_MASK;

  // OR-merge the status and read data of every register that is active and ready.
  // Registers are one-hot by construction, so a plain OR is enough.
  always_comb begin
    // NOTE: every always_comb output gets a default first so that no path can infer a latch.
    hit        = i_register_active & i_register_ready;
    any_active = |i_register_active;
    any_hit    = |hit;
    hit_status = '0;
    hit_data   = '0;
    for (int i = 0; i < REGISTERS; i++) begin
      if (hit[i]) begin
        hit_status = hit_status | i_register_status[2*i +: 2];
        hit_data   = hit_data | i_register_read_data[BUS_WIDTH*i +: BUS_WIDTH];
      end
    end
  end

`ifdef RGGEN_REGISTER_BUS_TIMEOUT_EN
  localparam int unsigned TIMEOUT_COUNT_WIDTH =
    (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

  logic [TIMEOUT_COUNT_WIDTH-1:0] timeout_count_q;
  logic [TIMEOUT_COUNT_WIDTH-1:0] timeout_count_d;

  // The count is the number of BUSY cycles already spent. The current cycle
  // expires when it would be the TIMEOUT_CYCLES-th.
  assign timeout_count_d = (state_q == BUSY) ? timeout_count_q + 1'b1 : '0;
  assign timeout_expired = (32'(timeout_count_q) + 32'd1) >= 32'(TIMEOUT_CYCLES);

  // The watchdog counts BUSY cycles and restarts from zero outside BUSY.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) timeout_count_q <= '0;
    else          timeout_count_q <= timeout_count_d;
  end
`else
  // Without the watchdog, BUSY waits for ever. The parameter stays in the
  // expression only so the interface is identical in both builds. That term
  // folds to a constant false.
  assign timeout_expired = 1'b0 && (TIMEOUT_CYCLES == 0);
`endif

  // Transaction FSM. Every output is a flop driven from this single block.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: datapath flops are reset too, because every output must read 0 during reset.
    if (!i_rst_n) begin
      state_q          <= IDLE;
      bus_ready_q      <= 1'b0;
      status_q         <= '0;
      read_data_q      <= '0;
      register_valid_q <= 1'b0;
      access_q         <= '0;
      address_q        <= '0;
      write_data_q     <= '0;
      strobe_q         <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so all flops update together at the edge.
      case (state_q)
        IDLE: begin
          if (i_bus_valid) begin
            access_q     <= i_bus_access;
            address_q    <= local_address;
            write_data_q <= i_bus_write_data;
            strobe_q     <= i_bus_strobe;
            if (reject) begin
              state_q     <= RESPONSE;
              bus_ready_q <= 1'b1;
              status_q    <= NO_HIT_STATUS;
              read_data_q <= response_data(i_bus_access[0], DEFAULT_READ_DATA);
            end else begin
              state_q          <= BUSY;
              register_valid_q <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (!any_active) begin
            state_q          <= RESPONSE;
            register_valid_q <= 1'b0;
            bus_ready_q      <= 1'b1;
            status_q         <= NO_HIT_STATUS;
            read_data_q      <= response_data(access_q[0], DEFAULT_READ_DATA);
          end else if (any_hit) begin
            state_q          <= RESPONSE;
            register_valid_q <= 1'b0;
            bus_ready_q      <= 1'b1;
            status_q         <= hit_status;
            read_data_q      <= response_data(access_q[0], hit_data);
          end else if (timeout_expired) begin
            state_q          <= RESPONSE;
            register_valid_q <= 1'b0;
            bus_ready_q      <= 1'b1;
            status_q         <= STATUS_SLVERR;
            read_data_q      <= response_data(access_q[0], DEFAULT_READ_DATA);
          end
        end
        RESPONSE: begin
          state_q     <= IDLE;
          bus_ready_q <= 1'b0;
        end
        default: begin
          state_q          <= IDLE;
          bus_ready_q      <= 1'b0;
          register_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_bus_ready           = bus_ready_q;
  assign o_bus_status          = status_q;
  assign o_bus_read_data       = read_data_q;
  assign o_register_valid      = register_valid_q;
  assign o_register_access     = access_q;
  assign o_register_address    = address_q;
  assign o_register_write_data = write_data_q;
  assign o_register_strobe     = strobe_q;

endmodule

// File: tb/tb_rggen_register_bus_initiator.sv
// Directed bench for rggen_register_bus_initiator.
// The block is configured as a 2-register block at 0x100..0x13F with
// pre-decode and error status enabled. Stimulus is driven and outputs are
// sampled on the falling clock edge.
module tb_rggen_register_bus_initiator;

  localparam int          AW  = 16;
  localparam int          LW  = 8;
  localparam int          BW  = 32;
  localparam int          NR  = 2;
  localparam logic [31:0] DEF = 32'hDEAD_BEEF;

  logic           clk;
  logic           rst_n;
  logic           bus_valid;
  logic [1:0]     bus_access;
  logic [AW-1:0]  bus_address;
  logic [BW-1:0]  bus_write_data;
  logic [BW-1:0]  bus_strobe;
  logic           bus_ready;
  logic [1:0]     bus_status;
  logic [BW-1:0]  bus_read_data;
  logic           reg_valid;
  logic [1:0]     reg_access;
  logic [LW-1:0]  reg_address;
  logic [BW-1:0]  reg_write_data;
  logic [BW-1:0]  reg_strobe;
  logic [NR-1:0]  reg_active;
  logic [NR-1:0]  reg_ready;
  logic [2*NR-1:0] reg_status;
  logic [BW*NR-1:0] reg_read_data;

  int checks = 0;
  int errors = 0;

  rggen_register_bus_initiator #(
    .ADDRESS_WIDTH      (AW),
    .LOCAL_ADDRESS_WIDTH(LW),
    .BUS_WIDTH          (BW),
    .REGISTERS          (NR),
    .PRE_DECODE         (1'b1),
    .BASE_ADDRESS       (16'h0100),
    .BYTE_SIZE          (64),
    .ERROR_STATUS       (1'b1),
    .DEFAULT_READ_DATA  (DEF),
    .TIMEOUT_CYCLES     (4)
  ) dut (
    .i_clk                (clk),
    .i_rst_n              (rst_n),
    .i_bus_valid          (bus_valid),
    .i_bus_access         (bus_access),
    .i_bus_address        (bus_address),
    .i_bus_write_data     (bus_write_data),
    .i_bus_strobe         (bus_strobe),
    .o_bus_ready          (bus_ready),
    .o_bus_status         (bus_status),
    .o_bus_read_data      (bus_read_data),
    .o_register_valid     (reg_valid),
    .o_register_access    (reg_access),
    .o_register_address   (reg_address),
    .o_register_write_data(reg_write_data),
    .o_register_strobe    (reg_strobe),
    .i_register_active    (reg_active),
    .i_register_ready     (reg_ready),
    .i_register_status    (reg_status),
    .i_register_read_data (reg_read_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic request(input logic [1:0] acc, input logic [AW-1:0] addr,
                         input logic [BW-1:0] wd, input logic [BW-1:0] st);
    bus_valid      = 1'b1;
    bus_access     = acc;
    bus_address    = addr;
    bus_write_data = wd;
    bus_strobe     = st;
  endtask

  task automatic regs(input logic [NR-1:0] act, input logic [NR-1:0] rdy,
                      input logic [2*NR-1:0] st, input logic [BW*NR-1:0] rd);
    reg_active    = act;
    reg_ready     = rdy;
    reg_status    = st;
    reg_read_data = rd;
  endtask

  initial begin
    rst_n = 1'b0;
    bus_valid = 1'b0; bus_access = '0; bus_address = '0; bus_write_data = '0; bus_strobe = '0;
    regs('0, '0, '0, '0);
    cyc(); cyc();
    check("rst_reg_valid", reg_valid, 0);
    check("rst_bus_ready", bus_ready, 0);
    check("rst_status", bus_status, 0);
    check("rst_read_data", bus_read_data, 0);
    rst_n = 1'b1;
    cyc();

    // Read hit on register 1. The host keeps valid through the response, and
    // the request is taken again only after one IDLE cycle.
    regs(2'b10, 2'b10, 4'b0000, {32'hA5A5_0001, 32'h0000_0000});
    request(2'b10, 16'h0104, '0, '0);
    cyc();
    check("a_c1_reg_valid", reg_valid, 1);
    check("a_c1_reg_address", reg_address, 8'h04);
    check("a_c1_reg_access", reg_access, 2'b10);
    check("a_c1_bus_ready", bus_ready, 0);
    cyc();
    check("a_c2_bus_ready", bus_ready, 1);
    check("a_c2_status", bus_status, 2'b00);
    check("a_c2_read_data", bus_read_data, 32'hA5A5_0001);
    check("a_c2_reg_valid", reg_valid, 0);
    cyc();
    check("a_c3_reg_valid", reg_valid, 0);
    check("a_c3_bus_ready", bus_ready, 0);
    check("a_c3_read_data_hold", bus_read_data, 32'hA5A5_0001);
    cyc();
    check("a_c4_reg_valid", reg_valid, 1);
    bus_valid = 1'b0;
    cyc();
    check("a_c5_bus_ready", bus_ready, 1);
    cyc();

    // Write with three wait states. Host bus changes while BUSY must be ignored.
    regs(2'b01, 2'b00, 4'b0000, {32'h0000_0000, 32'hFFFF_FFFF});
    request(2'b11, 16'h0108, 32'h1234_5678, 32'h0000_FFFF);
    for (int k = 1; k <= 4; k++) begin
      cyc();
      check($sformatf("b_c%0d_reg_valid", k), reg_valid, 1);
      check($sformatf("b_c%0d_reg_address", k), reg_address, 8'h08);
      check($sformatf("b_c%0d_reg_strobe", k), reg_strobe, 32'h0000_FFFF);
      check($sformatf("b_c%0d_reg_write_data", k), reg_write_data, 32'h1234_5678);
      check($sformatf("b_c%0d_bus_ready", k), bus_ready, 0);
      if (k == 1) begin
        bus_address    = 16'h0130;
        bus_write_data = 32'hFFFF_0000;
        bus_strobe     = 32'hFFFF_FFFF;
      end
      if (k == 4) reg_ready = 2'b01;
    end
    cyc();
    check("b_c5_bus_ready", bus_ready, 1);
    check("b_c5_status", bus_status, 2'b00);
    check("b_c5_read_data", bus_read_data, 32'h0000_0000);
    check("b_c5_reg_valid", reg_valid, 0);
    bus_valid = 1'b0;
    cyc();

    // Two registers respond together: their status and data are OR-merged.
    regs(2'b11, 2'b11, {2'b00, 2'b10}, {32'h0000_0F00, 32'h0000_00F0});
    request(2'b10, 16'h010C, '0, '0);
    cyc();
    check("c_c1_reg_valid", reg_valid, 1);
    cyc();
    check("c_c2_bus_ready", bus_ready, 1);
    check("c_c2_status", bus_status, 2'b10);
    check("c_c2_read_data", bus_read_data, 32'h0000_0FF0);
    bus_valid = 1'b0;
    cyc();

    // Pre-decode reject above the block, and then below it.
    regs('0, '0, '0, '0);
    request(2'b10, 16'h0140, '0, '0);
    cyc();
    check("e_hi_bus_ready", bus_ready, 1);
    check("e_hi_reg_valid", reg_valid, 0);
    check("e_hi_status", bus_status, 2'b11);
    check("e_hi_read_data", bus_read_data, DEF);
    bus_valid = 1'b0;
    cyc();
    check("e_hi_idle_reg_valid", reg_valid, 0);
    request(2'b10, 16'h00FC, '0, '0);
    cyc();
    check("e_lo_bus_ready", bus_ready, 1);
    check("e_lo_reg_valid", reg_valid, 0);
    bus_valid = 1'b0;
    cyc();

    // An in-range read that no register claims returns DECERR after one forwarded cycle.
    regs('0, '0, '0, '0);
    request(2'b10, 16'h0110, '0, '0);
    cyc();
    check("d_c1_reg_valid", reg_valid, 1);
    check("d_c1_bus_ready", bus_ready, 0);
    cyc();
    check("d_c2_bus_ready", bus_ready, 1);
    check("d_c2_status", bus_status, 2'b11);
    check("d_c2_read_data", bus_read_data, DEF);
    check("d_c2_reg_valid", reg_valid, 0);
    bus_valid = 1'b0;
    cyc();

    // Posted write hit: the access code is forwarded unchanged and no data is returned.
    regs(2'b01, 2'b01, 4'b0000, {32'h0000_0000, 32'h5555_AAAA});
    request(2'b01, 16'h011C, 32'hCAFE_F00D, 32'hFFFF_FFFF);
    cyc();
    check("f_c1_reg_access", reg_access, 2'b01);
    check("f_c1_reg_address", reg_address, 8'h1C);
    cyc();
    check("f_c2_bus_ready", bus_ready, 1);
    check("f_c2_read_data", bus_read_data, 32'h0000_0000);
    bus_valid = 1'b0;
    cyc();

    // A register is active but never ready.
    regs(2'b01, 2'b00, 4'b0000, '0);
    request(2'b10, 16'h0100, '0, '0);
`ifdef RGGEN_REGISTER_BUS_TIMEOUT_EN
    for (int k = 1; k <= 4; k++) begin
      cyc();
      check($sformatf("g_c%0d_reg_valid", k), reg_valid, 1);
      check($sformatf("g_c%0d_bus_ready", k), bus_ready, 0);
    end
    cyc();
    check("g_timeout_bus_ready", bus_ready, 1);
    check("g_timeout_status", bus_status, 2'b10);
    check("g_timeout_read_data", bus_read_data, DEF);
    check("g_timeout_reg_valid", reg_valid, 0);
    bus_valid = 1'b0;
    cyc();
`else
    begin
      int seen;
      seen = 0;
      repeat (100) begin
        cyc();
        if (bus_ready) seen++;
      end
      check("g_no_ready_count", seen, 0);
      check("g_still_busy", reg_valid, 1);
    end
    bus_valid = 1'b0;
`endif

    // Reset in the middle of BUSY drops the transaction and clears every output at once.
    request(2'b10, 16'h0104, 32'h1111_2222, 32'h3333_4444);
    cyc();
    cyc();
    rst_n = 1'b0;
    bus_valid = 1'b0;
    #1;
    check("h_rst_reg_valid", reg_valid, 0);
    check("h_rst_bus_ready", bus_ready, 0);
    check("h_rst_status", bus_status, 0);
    check("h_rst_read_data", bus_read_data, 0);
    check("h_rst_reg_address", reg_address, 0);
    check("h_rst_reg_access", reg_access, 0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // A normal read completes after the reset.
    regs(2'b10, 2'b10, 4'b0000, {32'hA5A5_0001, 32'h0000_0000});
    request(2'b10, 16'h0104, '0, '0);
    cyc();
    check("i_c1_reg_valid", reg_valid, 1);
    check("i_c1_reg_address", reg_address, 8'h04);
    cyc();
    check("i_c2_bus_ready", bus_ready, 1);
    check("i_c2_status", bus_status, 2'b00);
    check("i_c2_read_data", bus_read_data, 32'hA5A5_0001);
    bus_valid = 1'b0;
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
